// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM: byte-lane writes on port a, registered reads on port b,
// selectable collision policy, optional output stage and a post-reset clear sequencer.
module ram_sdp_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DATA_DEPTH     = 1024,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter string       RAM_STYLE_VAL  = "block",
    parameter string       MODE           = "WRITE_FIRST",
    parameter int unsigned OUT_REG        = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wen,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             ren,
    input  logic [ADDR_WIDTH-1:0]            addrb,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid,
    output logic                             init_busy
);

    localparam int unsigned           NB         = DATA_WIDTH / BYTE_WIDTH;
    localparam bit                    WriteFirst = (MODE == "WRITE_FIRST");
    localparam logic [ADDR_WIDTH:0]   DepthLim   = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr   = ADDR_WIDTH'(DATA_DEPTH - 1);

    // Parameter sanity checks, evaluated at elaboration.
    if (BYTE_WIDTH == 0 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : gen_bad_lanes
        $fatal(1, "ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (DATA_DEPTH == 0 || ADDR_WIDTH == 0 || ADDR_WIDTH > 31 ||
        DATA_DEPTH > (32'd1 << ADDR_WIDTH)) begin : gen_bad_depth
        $fatal(1, "ram_sdp_be: DATA_DEPTH does not fit in ADDR_WIDTH");
    end
    if (MODE != "WRITE_FIRST" && MODE != "READ_FIRST") begin : gen_bad_mode
        $fatal(1, "ram_sdp_be: MODE must be WRITE_FIRST or READ_FIRST");
    end
    if (OUT_REG > 1) begin : gen_bad_out_reg
        $fatal(1, "ram_sdp_be: OUT_REG must be 0 or 1");
    end
    if (CLEAR_ON_RESET > 1) begin : gen_bad_clear
        $fatal(1, "ram_sdp_be: CLEAR_ON_RESET must be 0 or 1");
    end
    if (RAM_STYLE_VAL != "block" && RAM_STYLE_VAL != "distributed") begin : gen_bad_style
        $fatal(1, "ram_sdp_be: RAM_STYLE_VAL must be block or distributed");
    end

    typedef enum logic {
        StIdle,
        StClear
    } clr_state_e;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    (* ram_style = RAM_STYLE_VAL *) logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic                  addr_ok_a, addr_ok_b;
    logic                  wr_fire, rd_fire, collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StIdle: begin
                clr_addr_d = '0;
            end
            StClear: begin
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                clr_addr_d = '0;
            end
        endcase
    end

    assign init_busy = (state_q == StClear);

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    assign addr_ok_a = ({1'b0, addra} < DepthLim);
    assign addr_ok_b = ({1'b0, addrb} < DepthLim);
    assign wr_fire   = wen && !init_busy && addr_ok_a;
    assign rd_fire   = ren && !init_busy;
    assign collide   = wr_fire && rd_fire && (addra == addrb);

    // Storage has no reset; only the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wbe[i]) begin
                    mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    // WRITE_FIRST forwards the lanes being written this edge over the old word.
    always_comb begin
        rd_word = '0;
        if (addr_ok_b) begin
            rd_word = mem[addrb];
            if (WriteFirst && collide) begin
                for (int i = 0; i < int'(NB); i++) begin
                    if (wbe[i]) begin
                        rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG == 1) begin : gen_out_reg
        logic [DATA_WIDTH-1:0] out_data_q;
        logic                  out_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    out_data_q <= rd_data_q;
                end
            end
        end

        assign dout       = out_data_q;
        assign dout_valid = out_valid_q;
    end else begin : gen_no_out_reg
        assign dout       = rd_data_q;
        assign dout_valid = rd_valid_q;
    end

    busy_no_valid_a : assert property (@(posedge clk) disable iff (!rst_n)
        init_busy |-> !dout_valid);
    clr_addr_range_a : assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, clr_addr_q} < DepthLim);

endmodule

// File: tb/tb_ram_sdp_be.sv
// Self-checking bench for ram_sdp_be: directed scenarios plus randomized traffic
// scored against an array-based model, across four parameterisations.
module tb_ram_sdp_be;

    localparam int DEPTH  = 16;
    localparam int SDEPTH = 12;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen   = 1'b0;
    logic        ren   = 1'b0;
    logic [3:0]  wbe   = '0;
    logic [3:0]  addra = '0;
    logic [3:0]  addrb = '0;
    logic [31:0] din   = '0;

    logic [31:0] dout_wf, dout_rf, dout_r0, dout_sm;
    logic        valid_wf, valid_rf, valid_r0, valid_sm;
    logic        busy_wf, busy_rf, busy_r0, busy_sm;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_sm  [SDEPTH];

    always #5 clk = ~clk;

    ram_sdp_be #(.DATA_WIDTH(32), .DATA_DEPTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                 .RAM_STYLE_VAL("block"), .MODE("WRITE_FIRST"), .OUT_REG(1),
                 .CLEAR_ON_RESET(1)) u_wf (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wbe(wbe), .addra(addra), .din(din),
        .ren(ren), .addrb(addrb), .dout(dout_wf), .dout_valid(valid_wf), .init_busy(busy_wf));

    ram_sdp_be #(.DATA_WIDTH(32), .DATA_DEPTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                 .RAM_STYLE_VAL("block"), .MODE("READ_FIRST"), .OUT_REG(1),
                 .CLEAR_ON_RESET(1)) u_rf (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wbe(wbe), .addra(addra), .din(din),
        .ren(ren), .addrb(addrb), .dout(dout_rf), .dout_valid(valid_rf), .init_busy(busy_rf));

    ram_sdp_be #(.DATA_WIDTH(32), .DATA_DEPTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                 .RAM_STYLE_VAL("distributed"), .MODE("WRITE_FIRST"), .OUT_REG(0),
                 .CLEAR_ON_RESET(1)) u_r0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wbe(wbe), .addra(addra), .din(din),
        .ren(ren), .addrb(addrb), .dout(dout_r0), .dout_valid(valid_r0), .init_busy(busy_r0));

    ram_sdp_be #(.DATA_WIDTH(32), .DATA_DEPTH(12), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
                 .RAM_STYLE_VAL("block"), .MODE("WRITE_FIRST"), .OUT_REG(1),
                 .CLEAR_ON_RESET(1)) u_sm (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wbe(wbe), .addra(addra), .din(din),
        .ren(ren), .addrb(addrb), .dout(dout_sm), .dout_valid(valid_sm), .init_busy(busy_sm));

    // Reference model: a word gets only the enabled lanes of the new data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        model_mem[a] = merge_lanes(model_mem[a], d, be);
        if (int'(a) < SDEPTH) model_sm[a] = merge_lanes(model_sm[a], d, be);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        for (int i = 0; i < SDEPTH; i++) model_sm[i] = '0;
    endtask

    task automatic go_idle();
        wen = 1'b0;
        ren = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int low_wf, low_rf, low_r0, low_sm, seen_valid;
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dout_wf, valid_wf, busy_wf} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_wf: got dout=%h valid=%b busy=%b, expected 0/0/1",
                     dout_wf, valid_wf, busy_wf);
        end
        checks++;
        if ({dout_r0, valid_r0, busy_r0} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_r0: got dout=%h valid=%b busy=%b, expected 0/0/1",
                     dout_r0, valid_r0, busy_r0);
        end
        checks++;
        if ({dout_sm, valid_sm, busy_sm} !== {32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_sm: got dout=%h valid=%b busy=%b, expected 0/0/1",
                     dout_sm, valid_sm, busy_sm);
        end
        // Hammer both ports during the clear; everything must be ignored.
        wen = 1'b1; ren = 1'b1; addra = 4'd1; addrb = 4'd1; din = 32'hFFFF_FFFF; wbe = 4'hF;
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy_rf !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_release: got %b, expected 1", busy_rf);
        end
        low_wf = 0; low_rf = 0; low_r0 = 0; low_sm = 0; seen_valid = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (!busy_wf && low_wf == 0) low_wf = c;
            if (!busy_rf && low_rf == 0) low_rf = c;
            if (!busy_r0 && low_r0 == 0) low_r0 = c;
            if (!busy_sm && low_sm == 0) low_sm = c;
            if (valid_wf || valid_rf || valid_r0 || valid_sm) seen_valid++;
            wen = busy_sm;
            ren = busy_sm;
        end
        checks++;
        if (low_wf != 16) begin
            errors++;
            $display("FAIL clear_len_wf: busy fell after %0d cycles, expected 16", low_wf);
        end
        checks++;
        if (low_rf != 16) begin
            errors++;
            $display("FAIL clear_len_rf: busy fell after %0d cycles, expected 16", low_rf);
        end
        checks++;
        if (low_r0 != 16) begin
            errors++;
            $display("FAIL clear_len_r0: busy fell after %0d cycles, expected 16", low_r0);
        end
        checks++;
        if (low_sm != 12) begin
            errors++;
            $display("FAIL clear_len_sm: busy fell after %0d cycles, expected 12", low_sm);
        end
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("FAIL clear_no_valid: got %0d valid pulses, expected 0", seen_valid);
        end
        model_clear();
        @(negedge clk);
        go_idle();
    endtask

    task automatic test_clear_zero();
        for (int n = 0; n <= 18; n++) begin
            @(negedge clk);
            if (n >= 2 && n < 18) begin
                checks++;
                if ({valid_wf, dout_wf} !== {1'b1, model_mem[n-2]}) begin
                    errors++;
                    $display("FAIL zero_wf addr=%0d: got valid=%b dout=%h, expected 1/%h",
                             n - 2, valid_wf, dout_wf, model_mem[n-2]);
                end
                checks++;
                if ({valid_sm, dout_sm} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL zero_sm addr=%0d: got valid=%b dout=%h, expected 1/0",
                             n - 2, valid_sm, dout_sm);
                end
            end
            if (n >= 1 && n < 17) begin
                checks++;
                if ({valid_r0, dout_r0} !== {1'b1, model_mem[n-1]}) begin
                    errors++;
                    $display("FAIL zero_r0 addr=%0d: got valid=%b dout=%h, expected 1/%h",
                             n - 1, valid_r0, dout_r0, model_mem[n-1]);
                end
            end
            if (n == 18) begin
                checks++;
                if (valid_wf !== 1'b0) begin
                    errors++;
                    $display("FAIL zero_train_end: got valid=%b, expected 0", valid_wf);
                end
            end
            ren   = (n < 16);
            addrb = 4'(n);
        end
        go_idle();
    endtask

    task automatic test_byte_lanes();
        @(negedge clk);
        wen = 1'b1; addra = 4'd3; din = 32'hAABB_CCDD; wbe = 4'b1111;
        model_write(addra, din, wbe);
        @(negedge clk);
        din = 32'h1122_3344; wbe = 4'b0101;
        model_write(addra, din, wbe);
        @(negedge clk);
        wen = 1'b0; ren = 1'b1; addrb = 4'd3;
        @(negedge clk);
        ren = 1'b0;
        checks++;
        if ({valid_r0, dout_r0} !== {1'b1, 32'hAA22_CC44}) begin
            errors++;
            $display("FAIL lanes_r0: got valid=%b dout=%h, expected 1/aa22cc44", valid_r0, dout_r0);
        end
        checks++;
        if (valid_wf !== 1'b0) begin
            errors++;
            $display("FAIL lanes_wf_early: got valid=%b one cycle after ren, expected 0", valid_wf);
        end
        @(negedge clk);
        checks++;
        if ({valid_wf, dout_wf} !== {1'b1, 32'hAA22_CC44}) begin
            errors++;
            $display("FAIL lanes_wf: got valid=%b dout=%h, expected 1/aa22cc44", valid_wf, dout_wf);
        end
        checks++;
        if ({valid_sm, dout_sm} !== {1'b1, 32'hAA22_CC44}) begin
            errors++;
            $display("FAIL lanes_sm: got valid=%b dout=%h, expected 1/aa22cc44", valid_sm, dout_sm);
        end
        @(negedge clk);
        checks++;
        if ({valid_wf, dout_wf} !== {1'b0, 32'hAA22_CC44}) begin
            errors++;
            $display("FAIL lanes_hold: got valid=%b dout=%h, expected 0/aa22cc44", valid_wf, dout_wf);
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wen = 1'b1; addra = 4'(i); din = 32'(i * i); wbe = 4'hF;
            model_write(addra, din, wbe);
        end
        for (int n = 0; n <= 12; n++) begin
            @(negedge clk);
            wen = 1'b0;
            if (n >= 2 && n < 12) begin
                checks++;
                if ({valid_wf, dout_wf} !== {1'b1, 32'((n - 2) * (n - 2))}) begin
                    errors++;
                    $display("FAIL b2b_wf idx=%0d: got valid=%b dout=%h, expected 1/%h",
                             n - 2, valid_wf, dout_wf, 32'((n - 2) * (n - 2)));
                end
            end
            if (n >= 1 && n < 11) begin
                checks++;
                if ({valid_r0, dout_r0} !== {1'b1, 32'((n - 1) * (n - 1))}) begin
                    errors++;
                    $display("FAIL b2b_r0 idx=%0d: got valid=%b dout=%h, expected 1/%h",
                             n - 1, valid_r0, dout_r0, 32'((n - 1) * (n - 1)));
                end
            end
            if (n == 12) begin
                checks++;
                if (valid_wf !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_end: got valid=%b after 10 pulses, expected 0", valid_wf);
                end
            end
            ren   = (n < 10);
            addrb = 4'(n);
        end
        go_idle();
    endtask

    task automatic test_collision();
        @(negedge clk);
        wen = 1'b1; addra = 4'd5; din = 32'h0; wbe = 4'hF;
        model_write(addra, din, wbe);
        @(negedge clk);
        ren = 1'b1; addrb = 4'd5; din = 32'h1234_5678; wbe = 4'hF;
        model_write(addra, din, wbe);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        checks++;
        if ({valid_r0, dout_r0} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL coll_r0: got valid=%b dout=%h, expected 1/12345678", valid_r0, dout_r0);
        end
        @(negedge clk);
        checks++;
        if ({valid_wf, dout_wf} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL coll_wf: got valid=%b dout=%h, expected 1/12345678", valid_wf, dout_wf);
        end
        checks++;
        if ({valid_rf, dout_rf} !== {1'b1, 32'h0000_0000}) begin
            errors++;
            $display("FAIL coll_rf: got valid=%b dout=%h, expected 1/00000000", valid_rf, dout_rf);
        end
        // Partial-lane collision: unwritten lanes come from the old word.
        wen = 1'b1; ren = 1'b1; addra = 4'd5; addrb = 4'd5; din = 32'hDEAD_BEEF; wbe = 4'b0011;
        model_write(addra, din, wbe);
        @(negedge clk);
        wen = 1'b0; ren = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_wf, dout_wf} !== {1'b1, 32'h1234_BEEF}) begin
            errors++;
            $display("FAIL coll_part_wf: got valid=%b dout=%h, expected 1/1234beef",
                     valid_wf, dout_wf);
        end
        checks++;
        if ({valid_rf, dout_rf} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL coll_part_rf: got valid=%b dout=%h, expected 1/12345678",
                     valid_rf, dout_rf);
        end
        go_idle();
    endtask

    task automatic test_out_reg0();
        @(negedge clk);
        wen = 1'b1; addra = 4'd2; din = 32'd4; wbe = 4'hF;
        model_write(addra, din, wbe);
        @(negedge clk);
        wen = 1'b0; ren = 1'b1; addrb = 4'd2;
        checks++;
        if (valid_r0 !== 1'b0) begin
            errors++;
            $display("FAIL r0_pre: got valid=%b before the read, expected 0", valid_r0);
        end
        @(negedge clk);
        ren = 1'b0;
        checks++;
        if ({valid_r0, dout_r0} !== {1'b1, 32'd4}) begin
            errors++;
            $display("FAIL r0_read: got valid=%b dout=%h, expected 1/00000004", valid_r0, dout_r0);
        end
        @(negedge clk);
        checks++;
        if ({valid_r0, dout_r0} !== {1'b0, 32'd4}) begin
            errors++;
            $display("FAIL r0_pulse: got valid=%b dout=%h, expected 0/00000004", valid_r0, dout_r0);
        end
        go_idle();
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        wen = 1'b1; addra = 4'd14; din = 32'hFFFF_FFFF; wbe = 4'hF;
        model_write(addra, din, wbe);
        @(negedge clk);
        wen = 1'b0; ren = 1'b1; addrb = 4'd14;
        @(negedge clk);
        addrb = 4'd2;
        @(negedge clk);
        ren = 1'b0;
        checks++;
        if ({valid_sm, dout_sm} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL oor_read_sm: got valid=%b dout=%h, expected 1/00000000", valid_sm, dout_sm);
        end
        checks++;
        if ({valid_wf, dout_wf} !== {1'b1, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL oor_inrange_wf: got valid=%b dout=%h, expected 1/ffffffff",
                     valid_wf, dout_wf);
        end
        @(negedge clk);
        checks++;
        if ({valid_sm, dout_sm} !== {1'b1, 32'd4}) begin
            errors++;
            $display("FAIL oor_alias_sm: got valid=%b dout=%h, expected 1/00000004", valid_sm, dout_sm);
        end
        go_idle();
    endtask

    task automatic test_random();
        logic        p1_v, p2_v, known1, known2;
        logic [31:0] p1_wf, p1_rf, p1_sm, p2_wf, p2_rf, p2_sm;
        logic [31:0] h_wf, h_rf, h_r0, h_sm, pre_main;
        p1_v = 1'b0; p2_v = 1'b0; known1 = 1'b0; known2 = 1'b0;
        p1_wf = '0; p1_rf = '0; p1_sm = '0; p2_wf = '0; p2_rf = '0; p2_sm = '0;
        h_wf = '0; h_rf = '0; h_r0 = '0; h_sm = '0; pre_main = '0;
        for (int n = 0; n < 404; n++) begin
            @(negedge clk);
            checks++;
            if (valid_wf !== p2_v) begin
                errors++;
                $display("FAIL rand_valid_wf n=%0d: got %b, expected %b", n, valid_wf, p2_v);
            end
            checks++;
            if (valid_rf !== p2_v) begin
                errors++;
                $display("FAIL rand_valid_rf n=%0d: got %b, expected %b", n, valid_rf, p2_v);
            end
            checks++;
            if (valid_sm !== p2_v) begin
                errors++;
                $display("FAIL rand_valid_sm n=%0d: got %b, expected %b", n, valid_sm, p2_v);
            end
            checks++;
            if (valid_r0 !== p1_v) begin
                errors++;
                $display("FAIL rand_valid_r0 n=%0d: got %b, expected %b", n, valid_r0, p1_v);
            end
            if (p2_v) begin
                h_wf = p2_wf; h_rf = p2_rf; h_sm = p2_sm; known2 = 1'b1;
            end
            if (p1_v) begin
                h_r0 = p1_wf; known1 = 1'b1;
            end
            if (known2) begin
                checks++;
                if (dout_wf !== h_wf) begin
                    errors++;
                    $display("FAIL rand_dout_wf n=%0d: got %h, expected %h", n, dout_wf, h_wf);
                end
                checks++;
                if (dout_rf !== h_rf) begin
                    errors++;
                    $display("FAIL rand_dout_rf n=%0d: got %h, expected %h", n, dout_rf, h_rf);
                end
                checks++;
                if (dout_sm !== h_sm) begin
                    errors++;
                    $display("FAIL rand_dout_sm n=%0d: got %h, expected %h", n, dout_sm, h_sm);
                end
            end
            if (known1) begin
                checks++;
                if (dout_r0 !== h_r0) begin
                    errors++;
                    $display("FAIL rand_dout_r0 n=%0d: got %h, expected %h", n, dout_r0, h_r0);
                end
            end
            p2_v = p1_v; p2_wf = p1_wf; p2_rf = p1_rf; p2_sm = p1_sm;
            if (n < 400) begin
                wen   = ($urandom_range(0, 1) == 1);
                ren   = ($urandom_range(0, 3) != 0);
                addra = 4'($urandom_range(0, 15));
                addrb = ($urandom_range(0, 1) == 1) ? addra : 4'($urandom_range(0, 15));
                wbe   = 4'($urandom_range(0, 15));
                din   = $urandom;
            end else begin
                wen = 1'b0;
                ren = 1'b0;
            end
            p1_v = ren;
            pre_main = model_mem[addrb];
            if (wen) model_write(addra, din, wbe);
            if (ren) begin
                p1_wf = model_mem[addrb];
                p1_rf = pre_main;
                p1_sm = (int'(addrb) < SDEPTH) ? model_sm[addrb] : 32'h0;
            end
        end
        go_idle();
    endtask

    task automatic test_reset_inflight();
        int low_wf, low_sm, seen_valid;
        @(negedge clk);
        wen = 1'b1; addra = 4'd7; din = 32'hCAFE_F00D; wbe = 4'hF;
        model_write(addra, din, wbe);
        @(negedge clk);
        wen = 1'b0; ren = 1'b1; addrb = 4'd7;
        @(negedge clk);
        ren = 1'b0;
        checks++;
        if ({valid_r0, dout_r0} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL inflight_r0: got valid=%b dout=%h, expected 1/cafef00d", valid_r0, dout_r0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_wf, valid_wf, dout_r0, valid_r0, busy_wf} !== {32'h0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL inflight_reset: got wf=%h/%b r0=%h/%b busy=%b, expected zeros, busy 1",
                     dout_wf, valid_wf, dout_r0, valid_r0, busy_wf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_wf, valid_wf, busy_wf, busy_sm} !== {32'h0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL midclear_reset: got dout=%h valid=%b busy=%b/%b, expected 0/0/1/1",
                     dout_wf, valid_wf, busy_wf, busy_sm);
        end
        @(negedge clk);
        rst_n = 1'b1;
        low_wf = 0; low_sm = 0; seen_valid = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (!busy_wf && low_wf == 0) low_wf = c;
            if (!busy_sm && low_sm == 0) low_sm = c;
            if (valid_wf || valid_rf || valid_r0 || valid_sm) seen_valid++;
        end
        checks++;
        if (low_wf != 16) begin
            errors++;
            $display("FAIL restart_len_wf: busy fell after %0d cycles, expected 16", low_wf);
        end
        checks++;
        if (low_sm != 12) begin
            errors++;
            $display("FAIL restart_len_sm: busy fell after %0d cycles, expected 12", low_sm);
        end
        checks++;
        if (seen_valid != 0) begin
            errors++;
            $display("FAIL restart_no_valid: got %0d valid pulses, expected 0", seen_valid);
        end
        model_clear();
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                checks++;
                if ({valid_wf, dout_wf} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL restart_zero_wf idx=%0d: got valid=%b dout=%h, expected 1/0",
                             n - 2, valid_wf, dout_wf);
                end
            end
            ren   = (n < 2);
            addrb = (n == 0) ? 4'd7 : 4'd3;
        end
        go_idle();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clear_zero();
        test_byte_lanes();
        test_back_to_back();
        test_collision();
        test_out_reg0();
        test_out_of_range();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
RAM_SDP_BE -- requirements
Module: ram_sdp_be

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width in bits.
REQ-002 The block SHALL have parameter DATA_DEPTH, default 1024, meaning the number of words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10, meaning the address width for ports a and b.
REQ-004 The block SHALL have parameter BYTE_WIDTH, default 8, meaning bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-005 The block SHALL have parameter RAM_STYLE_VAL, default "block", meaning the RAM style attribute ("block" or "distributed").
REQ-006 The block SHALL have parameter MODE, default "WRITE_FIRST", meaning the read/write collision policy ("WRITE_FIRST" or "READ_FIRST").
REQ-007 The block SHALL have parameter OUT_REG, default 1, meaning an extra output register stage (0 or 1).
REQ-008 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill of the memory after reset.
REQ-009 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-010 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 The block SHALL have port wen, input, 1 bit: write enable for port a.
REQ-012 The block SHALL have port wbe, input, NB bits: byte-lane write enables.
REQ-013 The block SHALL have port addra, input, ADDR_WIDTH bits: write address.
REQ-014 The block SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-015 The block SHALL have port ren, input, 1 bit: read enable for port b.
REQ-016 The block SHALL have port addrb, input, ADDR_WIDTH bits: read address.
REQ-017 The block SHALL have port dout, output, DATA_WIDTH bits: read data.
REQ-018 The block SHALL have port dout_valid, output, 1 bit: one-cycle pulse marking valid dout.
REQ-019 The block SHALL have port init_busy, output, 1 bit: high while the clear sequence runs.

Function
REQ-020 The block SHALL fail elaboration if DATA_WIDTH is not a multiple of BYTE_WIDTH, DATA_DEPTH > 2**ADDR_WIDTH, or MODE/OUT_REG is out of range.
REQ-021 At a rising edge with wen=1 and init_busy=0, the block SHALL write to mem[addra] only the byte lanes whose wbe[i]=1; the other lanes SHALL keep their value.
REQ-022 At a rising edge with ren=1 and init_busy=0, the block SHALL sample mem[addrb]; dout and dout_valid=1 SHALL appear 1+OUT_REG cycles later.
REQ-023 One read SHALL be accepted per cycle; back-to-back reads SHALL give contiguous dout_valid pulses in request order.
REQ-024 With no valid read, dout SHALL hold its last value and dout_valid SHALL be 0.
REQ-025 On a collision (wen=1, ren=1, addra==addrb, same edge) in WRITE_FIRST mode, the read SHALL return the newly written lanes merged with the old unwritten lanes.
REQ-026 On a collision in READ_FIRST mode, the read SHALL return the full pre-write word.
REQ-027 A write with addra >= DATA_DEPTH SHALL be ignored.
REQ-028 A read with addrb >= DATA_DEPTH SHALL return 0 with dout_valid=1.
REQ-029 The clear FSM SHALL have two states: IDLE and CLEAR.
REQ-030 When CLEAR_ON_RESET=1, the first clock after rst_n deasserts SHALL enter CLEAR; CLEAR SHALL write 0 to addresses 0..DATA_DEPTH-1, one per cycle, and then go to IDLE.
REQ-031 init_busy SHALL be 1 exactly while in CLEAR, which SHALL last DATA_DEPTH cycles.
REQ-032 While init_busy=1, the block SHALL ignore wen and ren and hold dout_valid at 0.
REQ-033 When CLEAR_ON_RESET=0, the FSM SHALL stay in IDLE, init_busy SHALL be 0, and initial memory contents are undefined.

Reset
REQ-034 While rst_n=0, the block SHALL force dout=0, dout_valid=0 and all read pipeline registers to 0, independent of clk.
REQ-035 While rst_n=0, the clear address SHALL be 0 and init_busy SHALL be 1 if CLEAR_ON_RESET=1, else 0.
REQ-036 Reset asserted during CLEAR or with reads in flight SHALL discard the in-flight reads; the clear SHALL restart from address 0.
REQ-037 Memory contents SHALL NOT be reset directly; only the clear FSM zeroes them.

Verification (DATA_DEPTH=16, ADDR_WIDTH=4, DATA_WIDTH=32, OUT_REG=1 unless noted)
REQ-038 The bench SHALL check: release rst_n -> init_busy=1 for exactly 16 cycles; then reads of addresses 0..15 return 0x00000000.
REQ-039 The bench SHALL check: write addr 3 din=0xAABBCCDD wbe=4'b1111, then addr 3 din=0x11223344 wbe=4'b0101, then read addr 3 -> dout=0xAA22CC44 two cycles after ren.
REQ-040 The bench SHALL check: write i*i to addresses 0..9, then read 0..9 back-to-back -> 10 contiguous dout_valid pulses carrying 0,1,4,...,81.
REQ-041 The bench SHALL check: with mem[5]=0x0 and a collision write 0x12345678 wbe=4'b1111 -> WRITE_FIRST returns 0x12345678, READ_FIRST returns 0x00000000.
REQ-042 The bench SHALL check: with OUT_REG=0, read addr 2 holding 4 -> dout=4 with dout_valid one cycle after ren.
REQ-043 The bench SHALL check: assert rst_n low at clear cycle 7 -> outputs 0 immediately; after release, init_busy=1 for 16 full cycles.
